// File: rtl/jtdsp16_icache.sv
// Loop instruction cache for DSP16 do/redo: records the loop body from ROM
// during the first pass, then replays it while the XAAU PC is frozen.
module jtdsp16_icache #(
    parameter int DEPTH = 15,
    parameter int KW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          do_en,
    input  logic          redo_en,
    input  logic [3:0]    ni,
    input  logic [KW-1:0] k,
    input  logic          adv,
    input  logic [15:0]   rom_dout,
    output logic [15:0]   cache_dout,
    output logic          cache_sel,
    output logic          pc_hold,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

    state_t        state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    rd_ptr_q, rd_ptr_d;
    logic [KW-1:0] kreg_q, kreg_d;
    logic [KW-1:0] iter_q, iter_d;
    logic [15:0]   mem [DEPTH];

    logic ni_ok;
    logic last_wr;
    logic last_rd;

    assign ni_ok   = (ni != 4'd0) && (ni <= 4'(DEPTH));
    assign last_wr = (wr_ptr_q == len_q - 4'd1);
    assign last_rd = (rd_ptr_q == len_q - 4'd1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        kreg_d   = kreg_q;
        iter_d   = iter_q;
        if (cen) begin
            case (state_q)
                IDLE: begin
                    // do_en takes priority over a simultaneous redo_en
                    if (do_en) begin
                        if (ni_ok) begin
                            len_d    = ni;
                            kreg_d   = k;
                            wr_ptr_d = 4'd0;
                            state_d  = FILL;
                        end
                    end else if (redo_en && len_q != 4'd0 && k != '0) begin
                        iter_d   = k;
                        rd_ptr_d = 4'd0;
                        state_d  = REPLAY;
                    end
                end
                FILL: begin
                    if (adv) begin
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        if (last_wr) begin
                            // the fill itself is the first iteration
                            if (kreg_q <= KW'(1)) begin
                                state_d = IDLE;
                            end else begin
                                iter_d   = kreg_q - KW'(1);
                                rd_ptr_d = 4'd0;
                                state_d  = REPLAY;
                            end
                        end
                    end
                end
                REPLAY: begin
                    if (adv) begin
                        if (last_rd) begin
                            rd_ptr_d = 4'd0;
                            if (iter_q == KW'(1)) state_d = IDLE;
                            else                  iter_d  = iter_q - KW'(1);
                        end else begin
                            rd_ptr_d = rd_ptr_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= 4'd0;
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            kreg_q   <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            kreg_q   <= kreg_d;
            iter_q   <= iter_d;
        end
    end

    // storage survives reset; only the bookkeeping is cleared
    always_ff @(posedge clk) begin
        if (cen && state_q == FILL && adv) mem[wr_ptr_q] <= rom_dout;
    end

    assign cache_sel  = (state_q == REPLAY);
    assign pc_hold    = (state_q == REPLAY);
    assign busy       = (state_q != IDLE);
    assign cache_dout = cache_sel ? mem[rd_ptr_q] : 16'd0;
endmodule

// File: tb/tb_jtdsp16_icache.sv
// Scoreboard bench for jtdsp16_icache: expected replay words are queued as
// the body is fetched and popped as the cache presents them.
module tb_jtdsp16_icache;
    localparam int KW = 7;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          cen = 1;
    logic          do_en = 0;
    logic          redo_en = 0;
    logic [3:0]    ni = 0;
    logic [KW-1:0] k = 0;
    logic          adv = 0;
    logic [15:0]   rom_dout = 0;
    logic [15:0]   cache_dout;
    logic          cache_sel;
    logic          pc_hold;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] body [16];
    logic [15:0] exp_q [$];

    jtdsp16_icache #(.DEPTH(15), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .do_en(do_en), .redo_en(redo_en),
        .ni(ni), .k(k), .adv(adv), .rom_dout(rom_dout),
        .cache_dout(cache_dout), .cache_sel(cache_sel), .pc_hold(pc_hold), .busy(busy)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    task push_body(input int n, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++) exp_q.push_back(body[i]);
    endtask

    task do_fill(input logic [3:0] n, input logic [KW-1:0] kk);
        do_en = 1; ni = n; k = kk;
        step;
        do_en = 0;
        for (int i = 0; i < int'(n); i++) begin
            rom_dout = body[i];
            adv = 1;
            n_chk++;
            if (busy !== 1'b1 || cache_sel !== 1'b0 || pc_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_flags word %0d: busy=%b sel=%b hold=%b, want 1 0 0", i, busy, cache_sel, pc_hold);
            end
            step;
        end
        adv = 0;
    endtask

    task drain_replay(input int budget);
        int cyc;
        logic [15:0] w;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            n_chk++;
            if (cache_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL replay_sel: cache_sel=%b with %0d words pending, want 1", cache_sel, exp_q.size());
                cyc = budget;
            end else begin
                w = exp_q.pop_front();
                if (cache_dout !== w || pc_hold !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL replay_word: dout=%h hold=%b busy=%b, want %h 1 1", cache_dout, pc_hold, busy, w);
                end
                adv = 1;
                step;
                adv = 0;
                cyc++;
            end
        end
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL replay_budget: %0d words left, want 0", exp_q.size());
        end
        exp_q.delete();
        n_chk++;
        if (cache_sel !== 1'b0 || pc_hold !== 1'b0 || busy !== 1'b0 || cache_dout !== 16'd0) begin
            n_fail++;
            $display("FAIL replay_end: sel=%b hold=%b busy=%b dout=%h, want 0 0 0 0000", cache_sel, pc_hold, busy, cache_dout);
        end
    endtask

    task test_reset;
        rst_n = 0;
        #12;
        n_chk++;
        if ({cache_sel, pc_hold, busy} !== 3'b000 || cache_dout !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel/hold/busy=%b dout=%h, want 000 0000", {cache_sel, pc_hold, busy}, cache_dout);
        end
        rst_n = 1;
        step;
        redo_en = 1; k = 3;
        step;
        redo_en = 0;
        n_chk++;
        if (busy !== 1'b0 || cache_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL redo_after_reset: busy=%b sel=%b, want 0 0", busy, cache_sel);
        end
    endtask

    task test_do_replay;
        body[0] = 16'hA0A0; body[1] = 16'hB1B1; body[2] = 16'hC2C2;
        do_fill(4'd3, 7'd2);
        push_body(3, 1);
        drain_replay(20);
    endtask

    task test_redo;
        redo_en = 1; k = 3;
        step;
        redo_en = 0;
        push_body(3, 3);
        drain_replay(30);
    endtask

    task test_single;
        body[0] = 16'h5A5A;
        do_fill(4'd1, 7'd1);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (busy !== 1'b0 || pc_hold !== 1'b0 || cache_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL single_idle cyc %0d: busy=%b hold=%b sel=%b, want 0 0 0", i, busy, pc_hold, cache_sel);
            end
            step;
        end
    endtask

    task test_bounds;
        do_en = 1; ni = 0; k = 5;
        step;
        do_en = 0;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ni0_ignored: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 15; i++) body[i] = 16'($urandom);
        do_fill(4'd15, 7'd127);
        push_body(15, 126);
        drain_replay(2000);
    endtask

    task test_stall;
        body[0] = 16'h1111; body[1] = 16'h2222; body[2] = 16'h3333;
        do_en = 1; ni = 3; k = 3;
        step;
        do_en = 0;
        rom_dout = body[0]; adv = 1;
        step;
        adv = 0; do_en = 1; ni = 2; k = 9; redo_en = 1;
        step;
        do_en = 0; redo_en = 0;
        for (int i = 1; i < 3; i++) begin
            rom_dout = body[i]; adv = 1;
            step;
        end
        adv = 0;
        n_chk++;
        if (cache_dout !== body[0] || cache_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first: dout=%h sel=%b, want %h 1", cache_dout, cache_sel, body[0]);
        end
        adv = 1;
        step;
        adv = 0;
        for (int i = 0; i < 4; i++) begin
            do_en = (i == 1); redo_en = (i == 2); ni = 1; k = 1;
            n_chk++;
            if (cache_dout !== body[1] || pc_hold !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: dout=%h hold=%b, want %h 1", i, cache_dout, pc_hold, body[1]);
            end
            step;
        end
        do_en = 0; redo_en = 0;
        cen = 0; adv = 1;
        for (int i = 0; i < 3; i++) begin
            step;
            n_chk++;
            if (cache_dout !== body[1] || cache_sel !== 1'b1) begin
                n_fail++;
                $display("FAIL cen_hold cyc %0d: dout=%h sel=%b, want %h 1", i, cache_dout, cache_sel, body[1]);
            end
        end
        cen = 1; adv = 0;
        exp_q.push_back(body[1]);
        exp_q.push_back(body[2]);
        push_body(3, 1);
        drain_replay(20);
    endtask

    task test_rst_mid;
        body[0] = 16'hDEAD; body[1] = 16'hBEEF;
        do_fill(4'd2, 7'd6);
        n_chk++;
        if (cache_dout !== body[0] || cache_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_replay: dout=%h sel=%b, want %h 1", cache_dout, cache_sel, body[0]);
        end
        #3 rst_n = 0;
        #1;
        n_chk++;
        if ({cache_sel, pc_hold, busy} !== 3'b000 || cache_dout !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: sel/hold/busy=%b dout=%h, want 000 0000", {cache_sel, pc_hold, busy}, cache_dout);
        end
        #2 rst_n = 1;
        step;
        redo_en = 1; k = 3;
        step;
        redo_en = 0;
        n_chk++;
        if (busy !== 1'b0 || cache_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL redo_len0: busy=%b sel=%b, want 0 0", busy, cache_sel);
        end
    endtask

    initial begin
        test_reset;
        test_do_replay;
        test_redo;
        test_single;
        test_bounds;
        test_stall;
        test_rst_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
